uart_rx_os: RTL

Receive half of the board UART. It samples the asynchronous serial input `uart_rx_i` at 16x the baud rate and deserialises 8N1 frames, LSB first. Each completed byte is presented on a hold register with a valid/read handshake, and framing and overrun errors are flagged. It sits beside the existing transmitter on the same 68 MHz system clock and shares its baud-generation scheme.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_rx_os.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the board UART: data width, default clock and line
// rate (common to receiver and transmitter) and the receiver FSM state type.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_CLK_HZ     = 68000000;
    localparam int UART_BAUD       = 115200;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Fractional rate generator. A free-running 32-bit phase accumulator adds RATE
// every clock; whenever the sum reaches CLK_HZ it wraps and tick pulses high
// for one cycle, so tick averages RATE pulses per second.
//
// Ports:
//   sys_clk_i    in   system clock
//   sys_rst_n_i  in   asynchronous active-low reset
//   tick         out  one-cycle rate pulse
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = UART_CLK_HZ,
    parameter int RATE   = UART_BAUD
) (
    input  logic sys_clk_i,
    input  logic sys_rst_n_i,
    output logic tick
);

    localparam logic [32:0] STEP  = 33'(RATE);
    localparam logic [32:0] LIMIT = 33'(CLK_HZ);

    logic [31:0] acc;
    logic [32:0] sum;

    // One extra bit so the compare is exact even near the top of the range.
    assign sum = {1'b0, acc} + STEP;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= LIMIT) begin
            acc  <= 32'(sum - LIMIT);
            tick <= 1'b1;
        end else begin
            acc  <= sum[31:0];
            tick <= 1'b0;
        end
    end

endmodule : uart_baud_tick

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// UART receiver, 8N1, LSB first, oversampled at OVERSAMPLE x BAUD. The start
// bit is qualified at its midpoint; data and stop bits are then sampled one
// bit period apart. Good bytes land in a hold register with a valid/read
// handshake; framing and overrun errors are single-cycle pulses.
//
// Ports:
//   sys_clk_i         in   system clock
//   sys_rst_n_i       in   asynchronous active-low reset
//   uart_rx_i         in   serial line (asynchronous, idles high)
//   uart_rd_i         in   read strobe, clears uart_valid_o
//   uart_dat_o        out  last accepted byte
//   uart_valid_o      out  byte available, held until read
//   uart_busy_r_o     out  receiver is not idle
//   uart_frame_err_o  out  pulse: stop bit sampled low
//   uart_overrun_o    out  pulse: good byte dropped, previous one unread
//
// OVERSAMPLE must be even and at least 8.
// -----------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = UART_CLK_HZ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_n_i,
    input  logic                   uart_rx_i,
    input  logic                   uart_rd_i,
    output logic [UART_DATA_W-1:0] uart_dat_o,
    output logic                   uart_valid_o,
    output logic                   uart_busy_r_o,
    output logic                   uart_frame_err_o,
    output logic                   uart_overrun_o
);

    localparam int                 SCNT_W    = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

    logic                   rx_meta;
    logic                   rx_s;
    logic                   tick;

    rx_state_e              state_q, state_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d, scnt_inc;
    logic [2:0]             bcnt_q, bcnt_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   load;
    logic                   overrun;
    logic                   frame_err;

    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // release never looks like a start bit.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .RATE   (BAUD * OVERSAMPLE)
    ) u_tick (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .tick        (tick)
    );

    // Sample counter wraps explicitly so non-power-of-two OVERSAMPLE works.
    assign scnt_inc = (scnt_q == SCNT_LAST) ? '0 : scnt_q + SCNT_W'(1);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        load      = 1'b0;
        overrun   = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    scnt_d  = '0;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (scnt_q == SCNT_MID) begin
                        // Still low at mid start bit: real frame. High: glitch.
                        if (!rx_s) begin
                            scnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        scnt_d = scnt_inc;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    scnt_d = scnt_inc;
                    if (scnt_q == SCNT_LAST) begin
                        // LSB arrives first, so shifting in at the MSB leaves
                        // the byte in natural order after eight bits.
                        shreg_d = {rx_s, shreg_q[UART_DATA_W-1:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    scnt_d = scnt_inc;
                    if (scnt_q == SCNT_LAST) begin
                        if (rx_s) begin
                            // A read in the same cycle frees the register.
                            if (!uart_valid_o || uart_rd_i) begin
                                load = 1'b1;
                            end else begin
                                overrun = 1'b1;
                            end
                            state_d = IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = BREAK;
                        end
                    end
                end
            end

            BREAK: begin
                // Wait out a held-low line so it cannot retrigger a start.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            uart_dat_o       <= '0;
            uart_valid_o     <= 1'b0;
            uart_frame_err_o <= 1'b0;
            uart_overrun_o   <= 1'b0;
        end else begin
            uart_frame_err_o <= frame_err;
            uart_overrun_o   <= overrun;
            if (load) begin
                uart_dat_o   <= shreg_q;
                uart_valid_o <= 1'b1;
            end else if (uart_rd_i) begin
                uart_valid_o <= 1'b0;
            end
        end
    end

    assign uart_busy_r_o = (state_q != IDLE);

endmodule : uart_rx_os
